// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: EX forwarding selects, load-use bubbles, branch flushes, dmem freezes, halt drain.
// Control outputs are Mealy (same cycle as the inputs); stall_all freezes the whole pipe while data memory is busy.
module hazard_ctrl #(
    parameter int DRAIN_CYC   = 3,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_hlt,
    input  logic [3:0]       ex_rs,
    input  logic [3:0]       ex_rt,
    input  logic [3:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memrd,
    input  logic [3:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic [3:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_bubble,
    output logic             stall_all,
    output logic [4:0]       flush,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int DRN_W  = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DRN_W-1:0]  DRN_INIT = DRN_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [4:0] FLUSH_BR = 5'b10011;
    localparam logic [4:0] FLUSH_IF = 5'b00001;

    typedef enum logic [1:0] {RUN, MEMWAIT, DRAIN, HALTED} state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [DRN_W-1:0]  drn_cnt, drn_nxt;
    logic              err_set;
    logic              load_use;
    logic [1:0]        fwd_a_raw, fwd_b_raw;
    logic              pc_stall_raw, ifid_stall_raw, idex_bubble_raw, stall_all_raw;
    logic [4:0]        flush_raw;

    // EX/MEM result is younger than MEM/WB, so it wins when both match.
    assign fwd_a_raw = (mem_regwrite && mem_rd != 4'd0 && mem_rd == ex_rs) ? 2'b01 :
                       (wb_regwrite  && wb_rd  != 4'd0 && wb_rd  == ex_rs) ? 2'b10 : 2'b00;
    assign fwd_b_raw = (mem_regwrite && mem_rd != 4'd0 && mem_rd == ex_rt) ? 2'b01 :
                       (wb_regwrite  && wb_rd  != 4'd0 && wb_rd  == ex_rt) ? 2'b10 : 2'b00;

    assign load_use = ex_memrd && ex_regwrite && ex_rd != 4'd0 &&
                      ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));

    always_comb begin
        state_nxt       = state;
        wait_nxt        = wait_cnt;
        drn_nxt         = drn_cnt;
        err_set         = 1'b0;
        pc_stall_raw    = 1'b0;
        ifid_stall_raw  = 1'b0;
        idex_bubble_raw = 1'b0;
        stall_all_raw   = 1'b0;
        flush_raw       = 5'b0;
        case (state)
            RUN, MEMWAIT: begin
                if (state == MEMWAIT && !dmem_ready) begin
                    stall_all_raw = 1'b1;
                    if (wait_cnt != WAIT_MAX)
                        wait_nxt = wait_cnt + WAIT_W'(1);
                    err_set = (wait_nxt == WAIT_MAX);
                end else if (dmem_req && !dmem_ready) begin
                    stall_all_raw = 1'b1;
                    state_nxt     = MEMWAIT;
                    wait_nxt      = WAIT_W'(1);
                    err_set       = (WAIT_MAX == WAIT_W'(1));
                end else begin
                    // Freeze released (or never taken): EX/ID decisions are evaluated normally.
                    state_nxt = RUN;
                    if (branch_taken) begin
                        flush_raw = FLUSH_BR;
                    end else if (load_use) begin
                        pc_stall_raw    = 1'b1;
                        ifid_stall_raw  = 1'b1;
                        idex_bubble_raw = 1'b1;
                    end else if (id_hlt) begin
                        pc_stall_raw = 1'b1;
                        flush_raw    = FLUSH_IF;
                        state_nxt    = DRAIN;
                        drn_nxt      = DRN_INIT;
                    end
                end
            end
            DRAIN: begin
                pc_stall_raw = 1'b1;
                flush_raw    = FLUSH_IF;
                if (dmem_req && !dmem_ready) begin
                    stall_all_raw = 1'b1;
                end else if (branch_taken) begin
                    // HLT was on the wrong path: redirect instead of draining.
                    pc_stall_raw = 1'b0;
                    flush_raw    = FLUSH_BR;
                    state_nxt    = RUN;
                end else if (drn_cnt == '0) begin
                    state_nxt = HALTED;
                end else begin
                    drn_nxt = drn_cnt - DRN_W'(1);
                end
            end
            HALTED: begin
                pc_stall_raw = 1'b1;
                flush_raw    = FLUSH_IF;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            drn_cnt   <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            drn_cnt  <= drn_nxt;
            if (err_set)
                mem_err <= 1'b1;
            if ((pc_stall_raw || stall_all_raw) && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Reset forces every combinational output low, independent of the inputs.
    assign fwd_a       = rst_n ? fwd_a_raw : 2'b00;
    assign fwd_b       = rst_n ? fwd_b_raw : 2'b00;
    assign pc_stall    = rst_n && pc_stall_raw;
    assign ifid_stall  = rst_n && ifid_stall_raw;
    assign idex_bubble = rst_n && idex_bubble_raw;
    assign stall_all   = rst_n && stall_all_raw;
    assign flush       = rst_n ? flush_raw : 5'b0;
    assign halted      = rst_n && (state == HALTED);
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed plan followed by randomized traffic, every cycle checked against a reference model.
module tb_hazard_ctrl;
    localparam int DRAIN_CYC = 3;
    localparam int TO [2] = '{255, 2};
    localparam int CW [2] = '{16, 4};

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic id_uses_rs, id_uses_rt, id_hlt, ex_regwrite, ex_memrd, mem_regwrite, wb_regwrite;
    logic branch_taken, dmem_req, dmem_ready;

    logic [1:0]  fa0, fb0, fa1, fb1;
    logic        pcs0, ifid0, bub0, sa0, hlt0, err0;
    logic        pcs1, ifid1, bub1, sa1, hlt1, err1;
    logic [4:0]  fl0, fl1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_hlt(id_hlt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memrd(ex_memrd), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .branch_taken(branch_taken), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .fwd_a(fa0), .fwd_b(fb0), .pc_stall(pcs0), .ifid_stall(ifid0),
        .idex_bubble(bub0), .stall_all(sa0), .flush(fl0), .halted(hlt0), .mem_err(err0), .stall_cnt(cnt0)
    );

    hazard_ctrl #(.DRAIN_CYC(DRAIN_CYC), .MEM_TIMEOUT(2), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_hlt(id_hlt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memrd(ex_memrd), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .branch_taken(branch_taken), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .fwd_a(fa1), .fwd_b(fb1), .pc_stall(pcs1), .ifid_stall(ifid1),
        .idex_bubble(bub1), .stall_all(sa1), .flush(fl1), .halted(hlt1), .mem_err(err1), .stall_cnt(cnt1)
    );

    // Reference model: pipeline situation tracked as plain flags and integer countdowns.
    bit m_halted, n_halted;
    int m_drain, n_drain;          // cycles of drain left, -1 when not draining
    bit m_wait, n_wait;
    int m_wlen, n_wlen;
    bit m_err [2];
    bit n_err [2];
    int m_cnt [2];
    int n_cnt [2];
    int e_fa, e_fb, e_flush;
    bit e_pcs, e_ifid, e_bub, e_sa, e_halted;

    // Snapshot of u0 taken at the last check point, for directed checks.
    logic [31:0] s_fa, s_pcs, s_ifid, s_bub, s_sa, s_flush, s_halted, s_err0, s_err1, s_cnt0;

    function automatic int fwd_ref(input logic [3:0] src);
        if (src == 0) return 0;
        if (mem_regwrite && mem_rd == src) return 1;
        if (wb_regwrite && wb_rd == src) return 2;
        return 0;
    endfunction

    function automatic void model_reset();
        m_halted = 0; m_drain = -1; m_wait = 0; m_wlen = 0;
        for (int k = 0; k < 2; k++) begin m_err[k] = 0; m_cnt[k] = 0; end
        n_halted = 0; n_drain = -1; n_wait = 0; n_wlen = 0;
        for (int k = 0; k < 2; k++) begin n_err[k] = 0; n_cnt[k] = 0; end
    endfunction

    function automatic void model_eval();
        bit lu, busy;
        e_fa = 0; e_fb = 0; e_flush = 0;
        e_pcs = 0; e_ifid = 0; e_bub = 0; e_sa = 0; e_halted = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        n_halted = m_halted; n_drain = m_drain; n_wait = m_wait; n_wlen = m_wlen;
        n_err = m_err; n_cnt = m_cnt;
        e_fa = fwd_ref(ex_rs);
        e_fb = fwd_ref(ex_rt);
        lu = ex_memrd && ex_regwrite && ex_rd != 0 &&
             ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        busy = dmem_req && !dmem_ready;
        if (m_halted) begin
            e_halted = 1; e_pcs = 1; e_flush = 1;
        end else if (m_drain >= 0) begin
            e_pcs = 1; e_flush = 1;
            if (busy) e_sa = 1;
            else if (branch_taken) begin e_pcs = 0; e_flush = 19; n_drain = -1; end
            else if (m_drain == 0) begin n_halted = 1; n_drain = -1; end
            else n_drain = m_drain - 1;
        end else if (m_wait && !dmem_ready) begin
            e_sa = 1; n_wlen = m_wlen + 1;
        end else begin
            n_wait = 0;
            if (busy) begin e_sa = 1; n_wait = 1; n_wlen = 1; end
            else if (branch_taken) e_flush = 19;
            else if (lu) begin e_pcs = 1; e_ifid = 1; e_bub = 1; end
            else if (id_hlt) begin e_pcs = 1; e_flush = 1; n_drain = DRAIN_CYC - 1; end
        end
        for (int k = 0; k < 2; k++) begin
            if (n_wait && n_wlen >= TO[k]) n_err[k] = 1;
            if (e_pcs || e_sa) n_cnt[k] = (m_cnt[k] + 1 > (1 << CW[k]) - 1) ? m_cnt[k] : m_cnt[k] + 1;
        end
    endfunction

    function automatic void model_commit();
        m_halted = n_halted; m_drain = n_drain; m_wait = n_wait; m_wlen = n_wlen;
        m_err = n_err; m_cnt = n_cnt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        model_eval();
        chk("fwd_a", 32'(fa0), e_fa);           chk("fwd_b", 32'(fb0), e_fb);
        chk("pc_stall", 32'(pcs0), 32'(e_pcs)); chk("ifid_stall", 32'(ifid0), 32'(e_ifid));
        chk("idex_bubble", 32'(bub0), 32'(e_bub)); chk("stall_all", 32'(sa0), 32'(e_sa));
        chk("flush", 32'(fl0), e_flush);        chk("halted", 32'(hlt0), 32'(e_halted));
        chk("mem_err", 32'(err0), 32'(m_err[0])); chk("stall_cnt", 32'(cnt0), m_cnt[0]);
        chk("u1_fwd", {28'd0, fa1, fb1}, (e_fa << 2) | e_fb);
        chk("u1_ctl", {27'd0, pcs1, ifid1, bub1, sa1, hlt1},
            {27'd0, e_pcs, e_ifid, e_bub, e_sa, e_halted});
        chk("u1_flush", 32'(fl1), e_flush);
        chk("u1_mem_err", 32'(err1), 32'(m_err[1])); chk("u1_stall_cnt", 32'(cnt1), m_cnt[1]);
        s_fa = 32'(fa0); s_pcs = 32'(pcs0); s_ifid = 32'(ifid0); s_bub = 32'(bub0); s_sa = 32'(sa0);
        s_flush = 32'(fl0); s_halted = 32'(hlt0); s_err0 = 32'(err0); s_err1 = 32'(err1); s_cnt0 = 32'(cnt0);
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic clr_in();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_hlt = 0;
        ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_regwrite = 0; ex_memrd = 0;
        mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
        branch_taken = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic rand_in();
        id_rs = 4'($urandom_range(0, 3)); id_rt = 4'($urandom_range(0, 3));
        ex_rs = 4'($urandom_range(0, 3)); ex_rt = 4'($urandom_range(0, 3));
        ex_rd = 4'($urandom_range(0, 3)); mem_rd = 4'($urandom_range(0, 3)); wb_rd = 4'($urandom_range(0, 3));
        id_uses_rs = 1'($urandom_range(0, 1)); id_uses_rt = 1'($urandom_range(0, 1));
        ex_regwrite = 1'($urandom_range(0, 1)); ex_memrd = 1'($urandom_range(0, 1));
        mem_regwrite = 1'($urandom_range(0, 1)); wb_regwrite = 1'($urandom_range(0, 1));
        id_hlt = ($urandom_range(0, 24) == 0);
        branch_taken = ($urandom_range(0, 7) == 0);
        dmem_req = ($urandom_range(0, 2) == 0);
        dmem_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        clr_in();
        model_reset();
        rst_n = 1'b0;
        #1;
        cycle(); cycle();
        chk("rst_cnt", s_cnt0, 0);
        rst_n = 1'b1;

        // Forwarding priority and R0 exclusion
        mem_regwrite = 1; mem_rd = 5; wb_regwrite = 1; wb_rd = 5; ex_rs = 5;
        cycle(); chk("fwd_exmem", s_fa, 1);
        mem_regwrite = 0;
        cycle(); chk("fwd_memwb", s_fa, 2);
        mem_regwrite = 1; mem_rd = 0; wb_rd = 0; ex_rs = 0;
        cycle(); chk("fwd_r0", s_fa, 0);

        // Load-use: one-cycle bubble
        clr_in();
        ex_memrd = 1; ex_regwrite = 1; ex_rd = 3; id_uses_rt = 1; id_rt = 3;
        cycle(); chk("lu_pc", s_pcs, 1); chk("lu_ifid", s_ifid, 1); chk("lu_bub", s_bub, 1);
        clr_in();
        cycle(); chk("lu_pc_off", s_pcs, 0); chk("lu_bub_off", s_bub, 0); chk("lu_cnt", s_cnt0, 1);

        // Branch beats load-use
        ex_memrd = 1; ex_regwrite = 1; ex_rd = 3; id_uses_rt = 1; id_rt = 3; branch_taken = 1;
        cycle(); chk("br_flush", s_flush, 5'b10011); chk("br_pc", s_pcs, 0); chk("br_bub", s_bub, 0);
        clr_in();

        // Memory wait: 4 frozen cycles then release
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 4; i++) begin cycle(); chk("mw_stall", s_sa, 1); end
        dmem_ready = 1;
        cycle(); chk("mw_release", s_sa, 0); chk("mw_err", s_err0, 0);
        clr_in();
        cycle(); chk("mw_err_to2", s_err1, 1);
        cycle(); chk("mw_err_held", s_err1, 1); chk("mw_cnt", s_cnt0, 5);

        // Halt drain
        id_hlt = 1;
        cycle(); chk("hlt_pc", s_pcs, 1); chk("hlt_flush", s_flush, 1);
        id_hlt = 0;
        for (int i = 0; i < DRAIN_CYC; i++) begin
            cycle(); chk("drain_pc", s_pcs, 1); chk("drain_halted", s_halted, 0);
        end
        cycle(); chk("halted", s_halted, 1);
        cycle(); chk("halted_stay", s_halted, 1);
        rst_n = 0; model_reset();
        cycle();
        rst_n = 1;

        // Halt aborted by a branch in the 2nd drain cycle
        id_hlt = 1;
        cycle();
        id_hlt = 0;
        cycle();
        branch_taken = 1;
        cycle(); chk("abort_flush", s_flush, 5'b10011);
        branch_taken = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(); chk("abort_halted", s_halted, 0); chk("abort_pc", s_pcs, 0);
        end

        // Asynchronous reset while frozen
        dmem_req = 1; dmem_ready = 0;
        cycle(); cycle();
        #2 rst_n = 0; model_reset();
        #1;
        chk("arst_stall", 32'(sa0), 0); chk("arst_pc", 32'(pcs0), 0);
        chk("arst_flush", 32'(fl0), 0); chk("arst_cnt", 32'(cnt0), 0); chk("arst_err", 32'(err1), 0);
        cycle();
        rst_n = 1; dmem_req = 0; dmem_ready = 0;
        cycle(); chk("post_rst_run", s_sa, 0); chk("post_rst_cnt", s_cnt0, 0);

        // Long wait reaching the default timeout
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 258; i++) begin
            cycle();
            if (i == 200) chk("to_not_yet", s_err0, 0);
        end
        chk("to_reached", s_err0, 1);
        dmem_ready = 1;
        cycle();
        clr_in();

        // Randomized traffic with periodic resets
        for (int r = 0; r < 30; r++) begin
            rst_n = 0; clr_in(); model_reset();
            cycle();
            rst_n = 1;
            for (int c = 0; c < 60; c++) begin
                rand_in();
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
